// File: rtl/frog_draw_pkg.sv
// Shared definitions for the object draw controller and the VGA object mux.
// Holds the layer codes driven on object_to_draw and the frog blink state enum.
package frog_draw_pkg;

    localparam int unsigned CODE_W = 8;

    localparam logic [CODE_W-1:0] CODE_BACKGROUND = 8'd0;
    localparam logic [CODE_W-1:0] CODE_WATERFALL  = 8'd1;
    localparam logic [CODE_W-1:0] CODE_LOG        = 8'd2;
    localparam logic [CODE_W-1:0] CODE_FROG       = 8'd3;
    localparam logic [CODE_W-1:0] CODE_ENDBANK    = 8'd4;
    localparam logic [CODE_W-1:0] CODE_FRENCH     = 8'd5;

    typedef enum logic [1:0] {
        BLINK_IDLE = 2'd0,
        BLINK_SHOW = 2'd1,
        BLINK_HIDE = 2'd2
    } blink_state_t;

endpackage

// File: rtl/frog_blink_timer.sv
// Frame-based frog blink timer. A blink_start pulse (re)starts a sequence that
// begins hidden, toggles visibility every BLINK_PERIOD frames and ends after
// BLINK_LEN frames. Counters only move on startOfFrame and saturate at zero.
module frog_blink_timer
    import frog_draw_pkg::*;
#(
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_LEN    = 64
)
(
    input  logic CLK,
    input  logic RESETn,
    input  logic startOfFrame,
    input  logic blink_start,
    output logic frog_visible,
    output logic frog_blinking
);

    localparam int FW = $clog2(BLINK_LEN + 1);
    localparam int PW = $clog2(BLINK_PERIOD + 1);

    localparam logic [FW-1:0] FRAMES_LOAD = FW'(BLINK_LEN);
    localparam logic [FW-1:0] FRAMES_ONE  = FW'(1);
    localparam logic [FW-1:0] FRAMES_ZERO = '0;
    localparam logic [PW-1:0] PHASE_LOAD  = PW'(BLINK_PERIOD);
    localparam logic [PW-1:0] PHASE_ONE   = PW'(1);
    localparam logic [PW-1:0] PHASE_ZERO  = '0;

    blink_state_t  r_state;
    blink_state_t  w_state_nxt;
    logic [FW-1:0] r_frames;
    logic [FW-1:0] w_frames_nxt;
    logic [FW-1:0] w_frames_dec;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic [PW-1:0] w_phase_dec;

    // Saturating decrements so a counter parked at zero never wraps.
    assign w_frames_dec = (r_frames == FRAMES_ZERO) ? FRAMES_ZERO : (r_frames - FRAMES_ONE);
    assign w_phase_dec  = (r_phase  == PHASE_ZERO)  ? PHASE_ZERO  : (r_phase  - PHASE_ONE);

    // State and counter registers; reset returns to IDLE with the frog visible.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= BLINK_IDLE;
            r_frames <= FRAMES_ZERO;
            r_phase  <= PHASE_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_frames <= w_frames_nxt;
            r_phase  <= w_phase_nxt;
        end
    end

    // Next-state logic; a restart wins over a coincident frame tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames;
        w_phase_nxt  = r_phase;
        if (blink_start) begin
            w_state_nxt  = BLINK_HIDE;
            w_frames_nxt = FRAMES_LOAD;
            w_phase_nxt  = PHASE_LOAD;
        end else if (startOfFrame && (r_state != BLINK_IDLE)) begin
            w_frames_nxt = w_frames_dec;
            w_phase_nxt  = w_phase_dec;
            if (w_frames_dec == FRAMES_ZERO) begin
                w_state_nxt = BLINK_IDLE;
                w_phase_nxt = PHASE_ZERO;
            end else if (w_phase_dec == PHASE_ZERO) begin
                w_state_nxt = (r_state == BLINK_HIDE) ? BLINK_SHOW : BLINK_HIDE;
                w_phase_nxt = PHASE_LOAD;
            end
        end
    end

    assign frog_visible  = (r_state != BLINK_HIDE);
    assign frog_blinking = (r_state != BLINK_IDLE);

endmodule

// File: rtl/object_draw_ctrl.sv
// Per-pixel layer arbiter with frame-level frog collision reporting.
// Optional frog blink timer is included when FROG_BLINK_EN is defined;
// otherwise blink_start is ignored and the frog is always drawn.
module object_draw_ctrl
    import frog_draw_pkg::*;
#(
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_LEN    = 64
)
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              startOfFrame,
    input  logic              frog_dr,
    input  logic              log_dr,
    input  logic              waterfall_dr,
    input  logic              endbank_dr,
    input  logic              french_dr,
    input  logic              blink_start,
    output logic [CODE_W-1:0] object_to_draw,
    output logic              col_valid,
    output logic              frog_on_log,
    output logic              frog_drowned,
    output logic              frog_home,
    output logic              frog_blinking
);

    logic              w_frog_visible;
    logic              w_frog_blinking;
    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] r_object_to_draw;
    logic              w_ev_log;
    logic              w_ev_water;
    logic              w_ev_bank;
    logic              r_seen_log;
    logic              r_seen_water;
    logic              r_seen_bank;
    logic              r_col_valid;
    logic              r_frog_on_log;
    logic              r_frog_drowned;
    logic              r_frog_home;

`ifdef FROG_BLINK_EN
    frog_blink_timer #(
        .BLINK_PERIOD (BLINK_PERIOD),
        .BLINK_LEN    (BLINK_LEN)
    ) u_blink_timer (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .startOfFrame  (startOfFrame),
        .blink_start   (blink_start),
        .frog_visible  (w_frog_visible),
        .frog_blinking (w_frog_blinking)
    );
`else
    logic w_unused_blink;
    assign w_unused_blink  = blink_start & (BLINK_PERIOD > 0) & (BLINK_LEN > 0);
    assign w_frog_visible  = 1'b1;
    assign w_frog_blinking = 1'b0;
`endif

    // Fixed-priority layer select; a hidden frog drops out so lower layers show.
    always_comb begin
        w_code = CODE_BACKGROUND;
        if (french_dr)
            w_code = CODE_FRENCH;
        else if (frog_dr && w_frog_visible)
            w_code = CODE_FROG;
        else if (log_dr)
            w_code = CODE_LOG;
        else if (endbank_dr)
            w_code = CODE_ENDBANK;
        else if (waterfall_dr)
            w_code = CODE_WATERFALL;
    end

    // Register the selected layer code for the downstream mux.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            r_object_to_draw <= CODE_BACKGROUND;
        else
            r_object_to_draw <= w_code;
    end

    // Collision events use the raw frog request, independent of blink visibility.
    assign w_ev_log   = frog_dr & log_dr;
    assign w_ev_water = frog_dr & waterfall_dr & ~log_dr;
    assign w_ev_bank  = frog_dr & endbank_dr;

    // Sticky per-frame accumulators; on a frame boundary report and reload with
    // this pixel's events so the boundary pixel belongs to the new frame.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_seen_log     <= 1'b0;
            r_seen_water   <= 1'b0;
            r_seen_bank    <= 1'b0;
            r_col_valid    <= 1'b0;
            r_frog_on_log  <= 1'b0;
            r_frog_drowned <= 1'b0;
            r_frog_home    <= 1'b0;
        end else begin
            r_col_valid <= startOfFrame;
            if (startOfFrame) begin
                r_frog_on_log  <= r_seen_log;
                r_frog_drowned <= r_seen_water & ~r_seen_log;
                r_frog_home    <= r_seen_bank;
                r_seen_log     <= w_ev_log;
                r_seen_water   <= w_ev_water;
                r_seen_bank    <= w_ev_bank;
            end else begin
                r_seen_log     <= r_seen_log   | w_ev_log;
                r_seen_water   <= r_seen_water | w_ev_water;
                r_seen_bank    <= r_seen_bank  | w_ev_bank;
            end
        end
    end

    assign object_to_draw = r_object_to_draw;
    assign col_valid      = r_col_valid;
    assign frog_on_log    = r_frog_on_log;
    assign frog_drowned   = r_frog_drowned;
    assign frog_home      = r_frog_home;
    assign frog_blinking  = w_frog_blinking;

endmodule

// File: doc/object_draw_ctrl.md
# object_draw_ctrl

Per-pixel layer arbiter and frame-level collision/blink controller placed directly upstream of the VGA object mux. Each cycle it resolves the draw requests of all screen objects into a single registered `object_to_draw` code by fixed priority. It also accumulates frog overlap events over each frame and reports them at frame boundaries. A frame-based blink timer hides the frog after a hit.

## Interface
Parameters:
- `BLINK_PERIOD`, 8: frames per frog visibility half-cycle while blinking (≥1).
- `BLINK_LEN`, 64: total frames a blink sequence lasts (≥1).

Ports:
- `CLK`  in  1  pixel clock; sole clock.
- `RESETn`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse at the first pixel of each frame.
- `frog_dr`, `log_dr`, `waterfall_dr`, `endbank_dr`, `french_dr`  in  1 each  object covers the current pixel (opaque).
- `blink_start`  in  1  one-cycle pulse; start or restart frog blink.
- `object_to_draw`  out  8  selected layer code for the mux.
- `col_valid`  out  1  one-cycle pulse; collision outputs updated.
- `frog_on_log`, `frog_drowned`, `frog_home`  out  1 each  previous-frame collision results.
- `frog_blinking`  out  1  blink sequence active.

## Operation
- Codes: BACKGROUND=0, WATERFALL=1, LOG=2, FROG=3, ENDBANK=4, FRENCH=5. Upper 5 bits always 0.
- Priority, high to low: FRENCH, FROG (only when visible), LOG, ENDBANK, WATERFALL, BACKGROUND.
- Frame accumulators are sticky within a frame, set from unmasked `frog_dr`:
  - `seen_log` on frog&log.
  - `seen_water` on frog&waterfall&!log.
  - `seen_bank` on frog&endbank.
- On `startOfFrame`:
  - `frog_on_log`←seen_log.
  - `frog_drowned`←seen_water&!seen_log.
  - `frog_home`←seen_bank.
  - `col_valid` pulses.
  - Accumulators reload with the current cycle's events, so the boundary pixel counts toward the new frame.
- Blink FSM states: IDLE, SHOW, HIDE.
  - `blink_start` from any state → HIDE; frame counter←BLINK_LEN, phase counter←BLINK_PERIOD.
  - Each `startOfFrame` in SHOW/HIDE decrements both counters.
  - When the phase counter reaches 0, toggle SHOW↔HIDE and reload BLINK_PERIOD.
  - When the frame counter reaches 0, go to IDLE.
  - `blink_start` coincident with `startOfFrame` has priority: restart, no decrement.
- The frog is visible in IDLE and SHOW. In HIDE, FROG is removed from arbitration only; collisions still use raw `frog_dr`.
- Counter widths: `$clog2(BLINK_LEN+1)` and `$clog2(BLINK_PERIOD+1)`. Counters saturate at 0 and never wrap.

## Timing
- `object_to_draw` is registered; 1-cycle latency from the `*_dr` inputs.
- Collision outputs and `col_valid` are registered on the cycle after `startOfFrame`. Outputs hold until the next frame.
- A visibility change takes effect on the cycle after the `startOfFrame` that causes it.
- Reset values:
  - `object_to_draw`=0; all collision outputs=0; `col_valid`=0; `frog_blinking`=0.
  - FSM=IDLE; accumulators and counters cleared.
- Reset mid-blink or mid-frame discards all state. The first `col_valid` after reset reports only events since reset.

## Configuration
- `FROG_BLINK_EN` defined: blink FSM, counters, and `frog_blinking` are active as above.
- Not defined:
  - No blink logic is synthesized.
  - `blink_start` is ignored.
  - `frog_blinking` is tied to 0.
  - The frog is always visible.

## Structure
- Package `frog_draw_pkg` holds:
  - The layer code localparams (shared with the mux).
  - The blink-state enum.
- Sub-module `frog_blink_timer`: FSM plus counters. Inputs: `startOfFrame`, `blink_start`. Outputs: `frog_visible`, `frog_blinking`. Instantiated only under `FROG_BLINK_EN`.

## Test plan
- Reset, then all `*_dr`=0 → `object_to_draw`=0; all outputs 0.
- `french_dr`,`frog_dr`,`log_dr`=1 same cycle → next cycle `object_to_draw`=5. Drop french → 3. Drop frog → 2.
- Frame with frog&waterfall pixels and no frog&log → after `startOfFrame`: `col_valid`=1 for one cycle, `frog_drowned`=1, `frog_on_log`=0.
- Frog&log and frog&waterfall&!log in the same frame → `frog_on_log`=1, `frog_drowned`=0. Frog&endbank on the `startOfFrame` cycle → `frog_home`=1 only at the following frame's report.
- BLINK_PERIOD=2, BLINK_LEN=6, `blink_start`, frog_dr held high:
  - Per-frame visibility is hidden, hidden, shown, shown, hidden, hidden, then always shown.
  - `frog_blinking` drops after frame 6.
  - Collision flags are still set during hidden frames.
- `blink_start` mid-sequence and coincident with `startOfFrame` → counters reload to 6/2 with no decrement that frame. Assert `RESETn` mid-blink → IDLE with frog visible immediately.
